// File: rtl/mem_arb_pkg.sv
// Shared types and default bus widths for the memory arbiter.
// Imported by the arbiter and by the CPU top level.
package mem_arb_pkg;

  localparam int MEM_ARB_AW = 5;
  localparam int MEM_ARB_DW = 8;
  localparam int MEM_ARB_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating host wait counter with clear.
// starve_o flags that the host has waited WAIT_MAX cycles.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int WAIT_MAX = MEM_ARB_WAIT_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic starve_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] MAXV = CW'(WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve_q, starve_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  // The flag is compared against the next count so it drops the cycle
  // after a clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAXV)) begin
      cnt_d = cnt_q + 1'b1;
    end
    starve_d = (cnt_d == MAXV);
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;

endmodule

// File: rtl/mem_arbiter.sv
// CPU/host arbiter for the shared synchronous-read memory.
// Define MEM_ARB_HALT_GATE_EN to grant the host only while cpu_halt=1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = MEM_ARB_AW,
  parameter int DW       = MEM_ARB_DW,
  parameter int WAIT_MAX = MEM_ARB_WAIT_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          cpu_halt,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_starve,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    state_q, state_d;
  logic          host_ack_q, host_ack_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          cpu_busy;
  logic          halt_ok;
  logic          gnt;
  logic          wait_inc;
  logic          wait_clr;

  assign cpu_busy = cpu_rd | cpu_wr;

`ifdef MEM_ARB_HALT_GATE_EN
  assign halt_ok = cpu_halt;
`else
  logic unused_halt;
  assign unused_halt = cpu_halt;
  assign halt_ok     = 1'b1;
`endif

  assign gnt = (state_q == IDLE) & host_req & ~cpu_busy
             & ~rst & halt_ok;

  assign host_gnt  = gnt;
  assign cpu_rdata = mem_rdata;

  // Memory port mux: host only in its granted slot, CPU otherwise.
  always_comb begin
    mem_rd    = cpu_rd;
    mem_wr    = cpu_wr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (gnt) begin
      mem_rd    = ~host_we;
      mem_wr    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Host transaction sequencing and read-data capture.
  always_comb begin
    state_d      = state_q;
    host_rdata_d = host_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = host_we ? ACK : RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_d      = ACK;
        host_rdata_d = mem_rdata;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    host_ack_d = (state_d == ACK);
  end

  // State and host-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;

  assign wait_inc = (state_q == IDLE) & host_req & ~gnt;
  assign wait_clr = gnt | ~host_req;

  mem_arb_starve_cnt #(
    .WAIT_MAX (WAIT_MAX)
  ) u_starve (
    .clk_i    (clk),
    .rst_i    (rst),
    .inc_i    (wait_inc),
    .clr_i    (wait_clr),
    .starve_o (host_starve)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps followed by
// random CPU/host traffic against a cycle-timeline reference model.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int WM = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cpu_rd, cpu_wr, cpu_halt;
  logic          host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, host_wdata, mem_wdata;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic          host_gnt, host_ack, host_starve, mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] ram [32] = '{default: '0};

  // Memory macro stand-in: synchronous read, read-before-write.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] <= mem_wdata;
  end

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WM)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_halt    (cpu_halt),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_starve (host_starve),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a cycle counter, one outstanding host
  // transaction with its scheduled ack cycle, a memory shadow
  // and the host's consecutive waiting-cycle count.
  int            cyc    = 0;
  bit            outst  = 0;
  int            ack_at = 0;
  bit            p_we   = 0;
  logic [DW-1:0] p_data = '0;
  logic [DW-1:0] sh [32] = '{default: '0};
  logic [DW-1:0] rd_exp  = '0;
  logic [DW-1:0] last_rd = '0;
  int            wcnt    = 0;
  bit            e_gnt, e_mrd, e_mwr, e_ack;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            pct = 20;
  bit            halt_def;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    e_gnt = !rst && !outst && host_req && !cpu_rd && !cpu_wr;
`ifdef MEM_ARB_HALT_GATE_EN
    e_gnt = e_gnt && cpu_halt;
`endif
    if (e_gnt) begin
      e_mrd   = !host_we;
      e_mwr   = host_we;
      e_addr  = host_addr;
      e_wdata = host_wdata;
    end else begin
      e_mrd   = cpu_rd;
      e_mwr   = cpu_wr;
      e_addr  = cpu_addr;
      e_wdata = cpu_wdata;
    end
    e_ack = outst && (cyc == ack_at);
    chk("host_gnt", 32'(host_gnt), 32'(e_gnt));
    chk("host_ack", 32'(host_ack), 32'(e_ack));
    chk("host_rdata", 32'(host_rdata), 32'(rd_exp));
    chk("host_starve", 32'(host_starve), 32'(wcnt == WM));
    chk("mem_rd", 32'(mem_rd), 32'(e_mrd));
    chk("mem_wr", 32'(mem_wr), 32'(e_mwr));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(last_rd));
  endtask

  task automatic tick();
    bit was;
    @(posedge clk);
    was = outst;
    if (rst) begin
      outst  = 0;
      rd_exp = '0;
      wcnt   = 0;
    end else begin
      if (was && !p_we && (cyc == ack_at - 1)) rd_exp = p_data;
      if (was && (cyc == ack_at)) outst = 0;
      if (e_gnt) begin
        outst  = 1;
        p_we   = host_we;
        ack_at = cyc + (host_we ? 1 : 2);
        p_data = sh[host_addr];
      end
      if (!host_req || e_gnt) wcnt = 0;
      else if (!was && wcnt < WM) wcnt++;
    end
    if (e_mrd) last_rd = sh[e_addr];
    if (e_mwr) sh[e_addr] = e_wdata;
    cyc++;
    #1;
  endtask

  task automatic new_host();
    host_req   = 1'b1;
    host_we    = 1'($urandom_range(1));
    host_addr  = AW'($urandom_range(31));
    host_wdata = DW'($urandom_range(255));
  endtask

  initial begin
`ifdef MEM_ARB_HALT_GATE_EN
    halt_def = 1'b1;
`else
    halt_def = 1'b0;
`endif
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_halt = halt_def;
    cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    tick();
    tick();
    settle();
    chk("rst_ack", 32'(host_ack), 32'h0);
    chk("rst_rdata", 32'(host_rdata), 32'h0);
    chk("rst_starve", 32'(host_starve), 32'h0);
    chk("rst_gnt", 32'(host_gnt), 32'h0);
    tick();
    rst = 1'b0;

    // Fill memory through the CPU port.
    for (int i = 0; i < 32; i++) begin
      cpu_wr    = 1'b1;
      cpu_addr  = AW'(i);
      cpu_wdata = (i == 3) ? 8'hA5 : DW'(i * 37 + 11);
      settle();
      tick();
    end
    cpu_wr = 1'b0;

    // CPU-only read.
    cpu_rd = 1'b1; cpu_addr = 5'h03;
    settle();
    chk("cpu_rd_addr", 32'(mem_addr), 32'h03);
    chk("cpu_rd_nogn", 32'(host_gnt), 32'h0);
    tick();
    cpu_rd = 1'b0;
    settle();
    chk("cpu_rdata_a5", 32'(cpu_rdata), 32'hA5);
    tick();

    // Host write in an idle slot.
    host_req = 1'b1; host_we = 1'b1;
    host_addr = 5'h10; host_wdata = 8'h3C;
    settle();
    chk("hw_gnt", 32'(host_gnt), 32'h1);
    chk("hw_memwr", 32'(mem_wr), 32'h1);
    tick();
    settle();
    chk("hw_ack", 32'(host_ack), 32'h1);
    tick();
    host_req = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 5'h10;
    settle();
    tick();
    cpu_rd = 1'b0;
    settle();
    chk("hw_readback", 32'(cpu_rdata), 32'h3C);
    tick();

    // Host read with a CPU read inside RD_WAIT.
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'h10;
    settle();
    chk("hr_gnt", 32'(host_gnt), 32'h1);
    tick();
    cpu_rd = 1'b1; cpu_addr = 5'h00;
    settle();
    chk("hr_wait_ack", 32'(host_ack), 32'h0);
    tick();
    cpu_rd = 1'b0;
    settle();
    chk("hr_ack", 32'(host_ack), 32'h1);
    chk("hr_rdata", 32'(host_rdata), 32'h3C);
    chk("hr_cpu0", 32'(cpu_rdata), 32'h0B);
    tick();
    host_req = 1'b0;

    // Contention and starvation.
    host_req = 1'b1; host_we = 1'b1;
    host_addr = 5'h07; host_wdata = 8'h99;
    cpu_rd = 1'b1; cpu_addr = 5'h01;
    for (int k = 1; k <= 20; k++) begin
      settle();
      chk("st_nogn", 32'(host_gnt), 32'h0);
      if (k == 15) chk("st_k15", 32'(host_starve), 32'h0);
      if (k == 16) chk("st_k16", 32'(host_starve), 32'h1);
      tick();
    end
    cpu_rd = 1'b0;
    settle();
    chk("st_gnt", 32'(host_gnt), 32'h1);
    chk("st_held", 32'(host_starve), 32'h1);
    tick();
    settle();
    chk("st_clear", 32'(host_starve), 32'h0);
    chk("st_ack", 32'(host_ack), 32'h1);
    tick();
    host_req = 1'b0;

    // Reset during RD_WAIT drops the transaction.
    host_req = 1'b1; host_we = 1'b0; host_addr = 5'h10;
    settle();
    chk("rr_gnt", 32'(host_gnt), 32'h1);
    tick();
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
    settle();
    chk("rr_noack", 32'(host_ack), 32'h0);
    chk("rr_rdata", 32'(host_rdata), 32'h0);
    chk("rr_starve", 32'(host_starve), 32'h0);
    chk("rr_regnt", 32'(host_gnt), 32'h1);
    tick();
    settle();
    tick();
    settle();
    chk("rr_ack2", 32'(host_ack), 32'h1);
    chk("rr_rdata2", 32'(host_rdata), 32'h3C);
    tick();
    host_req = 1'b0;

`ifdef MEM_ARB_HALT_GATE_EN
    // Host blocked until the CPU halts.
    cpu_halt = 1'b0;
    host_req = 1'b1; host_we = 1'b1;
    host_addr = 5'h02; host_wdata = 8'h55;
    settle();
    chk("hg_nogn", 32'(host_gnt), 32'h0);
    tick();
    cpu_halt = 1'b1;
    settle();
    chk("hg_gnt", 32'(host_gnt), 32'h1);
    tick();
    settle();
    chk("hg_ack", 32'(host_ack), 32'h1);
    tick();
    host_req = 1'b0;
`endif

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if (n % 64 == 0) begin
        r   = int'($urandom_range(2));
        pct = (r == 0) ? 20 : (r == 1) ? 60 : 97;
      end
      rst = ($urandom_range(199) == 0);
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      if (int'($urandom_range(99)) < pct) begin
        r = int'($urandom_range(19));
        if (r < 12) cpu_rd = 1'b1;
        else if (r < 19) cpu_wr = 1'b1;
        else begin cpu_rd = 1'b1; cpu_wr = 1'b1; end
      end
      cpu_addr  = AW'($urandom_range(31));
      cpu_wdata = DW'($urandom_range(255));
      cpu_halt  = 1'($urandom_range(1));
      if (host_req && e_ack) begin
        if ($urandom_range(1) == 1) new_host();
        else host_req = 1'b0;
      end else if (!host_req && $urandom_range(3) == 0) begin
        new_host();
      end
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
